// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: bus modes, RV32 width codes,
// FSM state encoding and fault classification helpers.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'b00,
    BUS_READ  = 2'b01,
    BUS_WRITE = 2'b10
  } bus_mode_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } lsu_state_e;

  function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
    if (store) return f3 > F3_W;
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3 == F3_H || f3 == F3_HU) && lo[0]) || (f3 == F3_W && lo != 2'b00);
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational data alignment: sub-word load extraction with sign/zero
// extension, and sub-word store merge into the word read from the bus.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] read_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_value,
  output logic [31:0] merged_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = read_word[8*byte_off +: 8];
    sel_half = byte_off[1] ? read_word[31:16] : read_word[15:0];
  end

  always_comb begin
    load_value = read_word;
    case (funct3)
      F3_B:    load_value = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_value = {24'd0, sel_byte};
      F3_H:    load_value = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_value = {16'd0, sel_half};
      default: load_value = read_word;
    endcase
  end

  always_comb begin
    merged_word = store_data;
    case (funct3)
      F3_B: begin
        merged_word = read_word;
        merged_word[8*byte_off +: 8] = store_data[7:0];
      end
      F3_H: begin
        merged_word = read_word;
        if (byte_off[1]) merged_word[31:16] = store_data[15:0];
        else             merged_word[15:0]  = store_data[15:0];
      end
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: word-wide bus master with read-modify-write
// for sub-word stores and extended write-back data for loads.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; operands latched on acceptance
// ST_READ  | bus read held for READ_LATENCY+1 cycles, data captured last
// ST_WRITE | single bus write cycle (SW or merged SB/SH word)
// ST_DONE  | one-cycle done pulse, faults and write-back valid
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_reg,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic        illegal,
  output logic        wb_enable,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic [31:0] mst_address,
  output logic [31:0] mst_write_data,
  output logic [1:0]  mst_mode,
  input  logic [31:0] mst_read_data
);

  localparam int CW = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'(READ_LATENCY);

  lsu_state_e  state, next_state;
  logic [CW-1:0] wait_cnt;
  logic        store_q, illegal_q, misaligned_q;
  logic [2:0]  funct3_q;
  logic [31:0] address_q, store_data_q, read_q;
  logic [4:0]  dest_q;
  logic [31:0] load_value, merged_word;
  logic        req_illegal, req_misaligned;

  always_comb begin
    req_illegal    = f3_illegal(is_store, funct3);
    req_misaligned = !req_illegal && f3_misaligned(funct3, address[1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      wait_cnt     <= '0;
      store_q      <= 1'b0;
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
      funct3_q     <= '0;
      address_q    <= '0;
      store_data_q <= '0;
      read_q       <= '0;
      dest_q       <= '0;
    end else begin
      state <= next_state;
      case (state)
        ST_IDLE: begin
          if (start) begin
            store_q      <= is_store;
            funct3_q     <= funct3;
            address_q    <= address;
            store_data_q <= store_data;
            dest_q       <= dest_reg;
            illegal_q    <= req_illegal;
            misaligned_q <= req_misaligned;
            wait_cnt     <= '0;
          end
        end
        ST_READ: begin
          if (wait_cnt == LAST_WAIT) read_q <= mst_read_data;
          else                       wait_cnt <= wait_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (req_illegal || req_misaligned)   next_state = ST_DONE;
          else if (is_store && funct3 == F3_W) next_state = ST_WRITE;
          else                                 next_state = ST_READ;
        end
      end
      ST_READ: begin
        if (wait_cnt == LAST_WAIT) next_state = store_q ? ST_WRITE : ST_DONE;
      end
      ST_WRITE: next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  lsu_align u_align (
    .funct3      (funct3_q),
    .byte_off    (address_q[1:0]),
    .read_word   (read_q),
    .store_data  (store_data_q),
    .load_value  (load_value),
    .merged_word (merged_word)
  );

  // Bus and write-back outputs are decoded from registered state only.
  always_comb begin
    busy           = (state != ST_IDLE);
    done           = (state == ST_DONE);
    misaligned     = done && misaligned_q;
    illegal        = done && illegal_q;
    wb_enable      = done && !store_q && !misaligned_q && !illegal_q;
    wb_reg         = dest_q;
    wb_data        = wb_enable ? load_value : 32'd0;
    mst_mode       = BUS_IDLE;
    mst_address    = 32'd0;
    mst_write_data = 32'd0;
    if (state == ST_READ) begin
      mst_mode    = BUS_READ;
      mst_address = {address_q[31:2], 2'b00};
    end else if (state == ST_WRITE) begin
      mst_mode       = BUS_WRITE;
      mst_address    = {address_q[31:2], 2'b00};
      mst_write_data = merged_word;
    end
  end

endmodule
